// File: rtl/cpu_core_pipe.sv
// Two-stage pipelined core: decode/operand fetch with write-back forwarding, then ALU/write-back.
// Includes ZERO/CARRY flags, a RUN/HALTED control FSM and a retired-instruction counter.
module cpu_core_pipe #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16,
    localparam int INSTR_W   = 6 + 3 * REG_ADDR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [INSTR_W-1:0]    instruction,
    input  logic                  resume,
    output logic [DATA_W-1:0]     result_out,
    output logic                  result_valid,
    output logic [REG_ADDR_W-1:0] result_rd,
    output logic                  flag_zero,
    output logic                  flag_carry,
    output logic                  illegal_op,
    output logic                  halted,
    output logic [CNT_W-1:0]      retired_cnt,
    output logic [REG_ADDR_W-1:0] dbg_rs,
    output logic [REG_ADDR_W-1:0] dbg_rt,
    output logic [DATA_W-1:0]     dbg_data1,
    output logic [DATA_W-1:0]     dbg_data2,
    output logic [5:0]            dbg_alu_op
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam int SH_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_AND  = 6'h02;
    localparam logic [5:0] OP_OR   = 6'h03;
    localparam logic [5:0] OP_XOR  = 6'h04;
    localparam logic [5:0] OP_SLL  = 6'h05;
    localparam logic [5:0] OP_SRL  = 6'h06;
    localparam logic [5:0] OP_SLTU = 6'h07;
    localparam logic [5:0] OP_HALT = 6'h3F;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready;
    // instr_valid is ignored (not queued) whenever instr_ready is low.
    state_t                  state, state_nxt;
    logic                    accept;
    logic                    id_valid;
    logic [INSTR_W-1:0]      id_instr;
    logic [5:0]              id_op;
    logic [REG_ADDR_W-1:0]   id_rs, id_rt, id_rd;
    logic [DATA_W-1:0]       op_a, op_b;
    logic [DATA_W-1:0]       alu_res;
    logic                    alu_carry;
    logic                    alu_legal;
    logic                    alu_halt;
    logic [DATA_W-1:0]       rf [NUM_REGS];
    logic                    instr_unused;

    assign instr_unused = id_instr[0];

    assign instr_ready = (state == RUN);
    assign halted      = (state == HALTED);
    assign accept      = instr_valid && instr_ready;

    assign id_op = id_instr[INSTR_W-1 -: 6];
    assign id_rs = id_instr[INSTR_W-7 -: REG_ADDR_W];
    assign id_rt = id_instr[INSTR_W-7-REG_ADDR_W -: REG_ADDR_W];
    assign id_rd = id_instr[INSTR_W-7-2*REG_ADDR_W -: REG_ADDR_W];

    // The result register doubles as the WB stage, so it is the forwarding source.
    always_comb begin
        op_a = rf[id_rs];
        op_b = rf[id_rt];
        if (result_valid && (result_rd == id_rs)) op_a = result_out;
        if (result_valid && (result_rd == id_rt)) op_b = result_out;
        if (id_rs == '0) op_a = '0;
        if (id_rt == '0) op_b = '0;
    end

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_legal = 1'b1;
        alu_halt  = 1'b0;
        case (id_op)
            OP_ADD:  {alu_carry, alu_res} = {1'b0, op_a} + {1'b0, op_b};
            OP_SUB:  {alu_carry, alu_res} = {1'b0, op_a} - {1'b0, op_b};
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLL:  alu_res = op_a << op_b[SH_W-1:0];
            OP_SRL:  alu_res = op_a >> op_b[SH_W-1:0];
            OP_SLTU: alu_res = (op_a < op_b) ? DATA_W'(1) : '0;
            OP_HALT: begin
                alu_legal = 1'b0;
                alu_halt  = 1'b1;
            end
            default: alu_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // A resume on the HALT acceptance edge is seen while still in RUN, so HALTED lasts >= 1 cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (accept && (instruction[INSTR_W-1 -: 6] == OP_HALT)) state_nxt = HALTED;
            HALTED:  if (resume) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid     <= 1'b0;
            id_instr     <= '0;
            result_valid <= 1'b0;
            result_out   <= '0;
            result_rd    <= '0;
            flag_zero    <= 1'b0;
            flag_carry   <= 1'b0;
            illegal_op   <= 1'b0;
            retired_cnt  <= '0;
        end else begin
            id_valid     <= accept;
            if (accept) id_instr <= instruction;
            result_valid <= id_valid && alu_legal;
            illegal_op   <= id_valid && !alu_legal && !alu_halt;
            if (id_valid && alu_legal) begin
                result_out  <= alu_res;
                result_rd   <= id_rd;
                flag_zero   <= (alu_res == '0);
                retired_cnt <= retired_cnt + CNT_W'(1);
                if ((id_op == OP_ADD) || (id_op == OP_SUB)) flag_carry <= alu_carry;
            end
        end
    end

    // R0 is never written, so it holds its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= DATA_W'(i);
        end else if (result_valid && (result_rd != '0)) begin
            rf[result_rd] <= result_out;
        end
    end

    assign dbg_rs     = id_rs;
    assign dbg_rt     = id_rt;
    assign dbg_data1  = op_a;
    assign dbg_data2  = op_b;
    assign dbg_alu_op = id_op;

endmodule

// File: tb/tb_cpu_core_pipe.sv
// Bench for cpu_core_pipe: directed vector table, halt/illegal/reset sequences and random
// instruction streams checked against a sequential instruction-set model.
module tb_cpu_core_pipe;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instruction;
    logic        resume;
    logic [7:0]  result_out;
    logic        result_valid;
    logic [2:0]  result_rd;
    logic        flag_zero, flag_carry, illegal_op, halted;
    logic [15:0] retired_cnt;
    logic [2:0]  dbg_rs, dbg_rt;
    logic [7:0]  dbg_data1, dbg_data2;
    logic [5:0]  dbg_alu_op;

    logic        d2_instr_ready;
    logic [7:0]  d2_result_out;
    logic        d2_result_valid;
    logic [2:0]  d2_result_rd;
    logic        d2_flag_zero, d2_flag_carry, d2_illegal_op, d2_halted;
    logic [1:0]  d2_retired_cnt;
    logic [2:0]  d2_dbg_rs, d2_dbg_rt;
    logic [7:0]  d2_dbg_data1, d2_dbg_data2;
    logic [5:0]  d2_dbg_alu_op;

    cpu_core_pipe dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .resume(resume), .result_out(result_out),
        .result_valid(result_valid), .result_rd(result_rd), .flag_zero(flag_zero),
        .flag_carry(flag_carry), .illegal_op(illegal_op), .halted(halted),
        .retired_cnt(retired_cnt), .dbg_rs(dbg_rs), .dbg_rt(dbg_rt),
        .dbg_data1(dbg_data1), .dbg_data2(dbg_data2), .dbg_alu_op(dbg_alu_op)
    );

    cpu_core_pipe #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(d2_instr_ready),
        .instruction(instruction), .resume(resume), .result_out(d2_result_out),
        .result_valid(d2_result_valid), .result_rd(d2_result_rd), .flag_zero(d2_flag_zero),
        .flag_carry(d2_flag_carry), .illegal_op(d2_illegal_op), .halted(d2_halted),
        .retired_cnt(d2_retired_cnt), .dbg_rs(d2_dbg_rs), .dbg_rt(d2_dbg_rt),
        .dbg_data1(d2_dbg_data1), .dbg_data2(d2_dbg_data2), .dbg_alu_op(d2_dbg_alu_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid;
        logic       legal;
        logic       illegal;
        logic [5:0] op;
        logic [2:0] rs, rt, rd;
        logic [7:0] a, b, res;
        logic       c;
    } item_t;

    typedef struct {
        logic [15:0] ins;
        logic [7:0]  res;
        logic        z;
        logic        c;
    } vec_t;

    int          checks;
    int          failures;
    logic [7:0]  m_regs [8];
    logic        m_halted, m_zero, m_carry;
    logic [15:0] m_cnt;
    item_t       pend, cur;
    vec_t        vecs [14];

    function automatic logic [15:0] enc(logic [5:0] op, logic [2:0] rs, logic [2:0] rt, logic [2:0] rd);
        return {op, rs, rt, rd, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'(i);
        m_halted = 1'b0;
        m_zero   = 1'b0;
        m_carry  = 1'b0;
        m_cnt    = '0;
        pend     = '0;
        cur      = '0;
    endtask

    // Asserted right after a clock edge, so it also lands mid-pipeline when ops are in flight.
    task automatic do_reset();
        instr_valid = 1'b0;
        instruction = '0;
        resume      = 1'b0;
        rst_n       = 1'b0;
        model_reset();
        #2;
        chk("rst_result_valid", result_valid, 0);
        chk("rst_result_out", result_out, 0);
        chk("rst_result_rd", result_rd, 0);
        chk("rst_flags", {flag_zero, flag_carry, illegal_op, halted}, 0);
        chk("rst_retired_cnt", retired_cnt, 0);
        chk("rst_instr_ready", instr_ready, 1);
        chk("rst_dbg", {dbg_rs, dbg_rt, dbg_data1, dbg_data2, dbg_alu_op}, 0);
        chk("rst_cnt2", d2_retired_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock of stimulus. The model executes accepted instructions in program order;
    // the pipeline must show that result one cycle after the acceptance edge.
    task automatic cycle(input logic v, input logic [15:0] ins, input logic res);
        item_t np;
        int    t;
        instr_valid = v;
        instruction = ins;
        resume      = res;
        chk("instr_ready", instr_ready, !m_halted);
        np = '0;
        if (v && !m_halted) begin
            np.valid = 1'b1;
            np.op    = ins[15:10];
            np.rs    = ins[9:7];
            np.rt    = ins[6:4];
            np.rd    = ins[3:1];
            np.a     = m_regs[np.rs];
            np.b     = m_regs[np.rt];
            np.legal = (np.op <= 6'h07);
            np.illegal = !np.legal && (np.op != 6'h3F);
            case (np.op)
                6'h00: begin t = int'(np.a) + int'(np.b); np.res = 8'(t % 256); np.c = (t > 255); end
                6'h01: begin t = int'(np.a) - int'(np.b); np.res = 8'((t + 256) % 256); np.c = (t < 0); end
                6'h02: np.res = np.a & np.b;
                6'h03: np.res = np.a | np.b;
                6'h04: np.res = np.a ^ np.b;
                6'h05: np.res = 8'((int'(np.a) << (np.b % 8)) % 256);
                6'h06: np.res = np.a >> (np.b % 8);
                6'h07: np.res = (np.a < np.b) ? 8'd1 : 8'd0;
                default: np.res = '0;
            endcase
            if (np.legal && np.rd != 0) m_regs[np.rd] = np.res;
            if (np.op == 6'h3F) m_halted = 1'b1;
        end else if (m_halted && res) begin
            m_halted = 1'b0;
        end
        @(posedge clk);
        #1;
        cur  = pend;
        pend = np;
        if (cur.valid && cur.legal) begin
            m_zero = (cur.res == 0);
            if (cur.op <= 6'h01) m_carry = cur.c;
            m_cnt++;
        end
        chk("result_valid", result_valid, cur.valid && cur.legal);
        if (cur.valid && cur.legal) begin
            chk("result_out", result_out, cur.res);
            chk("result_rd", result_rd, cur.rd);
        end
        chk("illegal_op", illegal_op, cur.valid && cur.illegal);
        chk("flag_zero", flag_zero, m_zero);
        chk("flag_carry", flag_carry, m_carry);
        chk("retired_cnt", retired_cnt, m_cnt);
        chk("retired_cnt_w2", d2_retired_cnt, m_cnt[1:0]);
        chk("halted", halted, m_halted);
        if (pend.valid) begin
            chk("dbg_idx", {dbg_rs, dbg_rt}, {pend.rs, pend.rt});
            chk("dbg_data1", dbg_data1, pend.a);
            chk("dbg_data2", dbg_data2, pend.b);
            chk("dbg_alu_op", dbg_alu_op, pend.op);
        end
        instr_valid = 1'b0;
        resume      = 1'b0;
    endtask

    initial begin
        logic [15:0] add_ins;
        logic [5:0]  rop;
        int          r;
        checks   = 0;
        failures = 0;

        vecs[0]  = '{enc(6'h00, 2, 3, 1), 8'd5,   1'b0, 1'b0};
        vecs[1]  = '{enc(6'h00, 1, 1, 6), 8'd10,  1'b0, 1'b0};
        vecs[2]  = '{enc(6'h01, 3, 2, 4), 8'd1,   1'b0, 1'b0};
        vecs[3]  = '{enc(6'h01, 2, 3, 7), 8'd255, 1'b0, 1'b1};
        vecs[4]  = '{enc(6'h02, 2, 3, 5), 8'd2,   1'b0, 1'b1};
        vecs[5]  = '{enc(6'h04, 2, 2, 1), 8'd0,   1'b1, 1'b1};
        vecs[6]  = '{enc(6'h00, 2, 3, 0), 8'd5,   1'b0, 1'b0};
        vecs[7]  = '{enc(6'h00, 0, 0, 1), 8'd0,   1'b1, 1'b0};
        vecs[8]  = '{enc(6'h03, 6, 4, 3), 8'd11,  1'b0, 1'b0};
        vecs[9]  = '{enc(6'h05, 4, 3, 2), 8'd8,   1'b0, 1'b0};
        vecs[10] = '{enc(6'h06, 7, 3, 4), 8'd31,  1'b0, 1'b0};
        vecs[11] = '{enc(6'h07, 2, 4, 5), 8'd1,   1'b0, 1'b0};
        vecs[12] = '{enc(6'h07, 4, 2, 6), 8'd0,   1'b1, 1'b0};
        vecs[13] = '{enc(6'h00, 7, 7, 7), 8'd254, 1'b0, 1'b1};

        rst_n = 1'b0;
        #3;
        do_reset();

        // Back-to-back table: each result is checked one call after its issue.
        for (int i = 0; i <= 14; i++) begin
            if (i < 14) cycle(1'b1, vecs[i].ins, 1'b0);
            else        cycle(1'b0, '0, 1'b0);
            if (i > 0) begin
                chk("vec_valid", result_valid, 1);
                chk("vec_result", result_out, vecs[i-1].res);
                chk("vec_zero", flag_zero, vecs[i-1].z);
                chk("vec_carry", flag_carry, vecs[i-1].c);
                chk("vec_cnt", retired_cnt, i);
            end
        end

        // HALT, then an ADD held valid while halted, then resume.
        add_ins = enc(6'h00, 2, 3, 1);
        cycle(1'b1, enc(6'h3F, 0, 0, 0), 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, add_ins, 1'b0);
        chk("halt_hold_halted", halted, 1);
        chk("halt_hold_ready", instr_ready, 0);
        chk("halt_hold_cnt", retired_cnt, 14);
        cycle(1'b1, add_ins, 1'b1);
        cycle(1'b1, add_ins, 1'b0);
        cycle(1'b0, '0, 1'b0);
        chk("resume_add_valid", result_valid, 1);
        chk("resume_add_result", result_out, 8'd19);

        // Resume coinciding with HALT acceptance still leaves a halted cycle.
        cycle(1'b1, enc(6'h3F, 0, 0, 0), 1'b1);
        chk("halt_coincide", halted, 1);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1);
        chk("halt_released", halted, 0);

        // Illegal opcode: one-cycle pulse, destination untouched.
        cycle(1'b1, enc(6'h20, 1, 2, 3), 1'b0);
        cycle(1'b0, '0, 1'b0);
        chk("illegal_pulse", illegal_op, 1);
        chk("illegal_no_result", result_valid, 0);
        cycle(1'b1, enc(6'h00, 3, 0, 4), 1'b0);
        chk("illegal_pulse_end", illegal_op, 0);
        cycle(1'b0, '0, 1'b0);
        chk("illegal_no_write", result_out, 8'd11);

        // Reset with an op in flight: register file returns to R[i]=i.
        cycle(1'b1, enc(6'h00, 5, 5, 3), 1'b0);
        do_reset();
        for (int i = 1; i < 8; i++) begin
            cycle(1'b1, enc(6'h00, 3'(i), 0, 3'(i)), 1'b0);
            if (i > 1) chk("post_rst_reg", result_out, i - 1);
        end
        cycle(1'b0, '0, 1'b0);
        chk("post_rst_reg7", result_out, 7);
        chk("cnt_w2_wrap", d2_retired_cnt, 2'd3);

        // Random stream with occasional HALT, illegal opcodes and stray resumes.
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 19);
            if (r < 16)       rop = 6'(r % 8);
            else if (r == 16) rop = 6'h3F;
            else              rop = 6'($urandom_range(8, 62));
            cycle($urandom_range(0, 3) != 0,
                  {rop, 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1))},
                  $urandom_range(0, 3) == 0);
        end
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
